// File: rtl/wdg_ctrl.sv
// -----------------------------------------------------------------------------
// wdg_ctrl - two-stage windowed watchdog controller
//
// Counts rising edges of the mtime time-base bit. Stage 1 expiry raises a
// pre-warning interrupt; stage 2 expiry (counted after stage 1) issues a
// sticky system reset request. In RUN an optional window rejects early kicks,
// and an early kick is treated as a fatal fault.
//
// Ports:
//   clk           system clock
//   res           asynchronous active-high reset
//   wdg_tick      mtime time-base bit; each 0->1 transition is one tick
//   cfg_en        watchdog enable (level)
//   cfg_timeout1  stage-1 timeout in ticks (0 behaves as 1)
//   cfg_timeout2  stage-2 timeout in ticks (0 behaves as 1)
//   cfg_window    earliest legal kick count in RUN; 0 disables the window
//   kick          single-cycle service pulse
//   irq_clr       single-cycle pulse clearing wdg_irq without servicing
//   wdg_irq       pre-warning interrupt (level)
//   wdg_rst_req   system reset request (sticky until res)
//   kick_err      sticky early-kick flag
//   wdg_state     IDLE=0, RUN=1, PREWARN=2, EXPIRED=3
//   wdg_cnt       current tick count
// -----------------------------------------------------------------------------
module wdg_ctrl #(
  parameter int CNT_W         = 16,
  parameter bit ALLOW_DISABLE = 1'b1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             wdg_tick,
  input  logic             cfg_en,
  input  logic [CNT_W-1:0] cfg_timeout1,
  input  logic [CNT_W-1:0] cfg_timeout2,
  input  logic [CNT_W-1:0] cfg_window,
  input  logic             kick,
  input  logic             irq_clr,
  output logic             wdg_irq,
  output logic             wdg_rst_req,
  output logic             kick_err,
  output logic [1:0]       wdg_state,
  output logic [CNT_W-1:0] wdg_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_PREWARN  = 2'd2,
    ST_EXPIRED  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // A zero timeout would never match a wrapped count of -1 in a useful way,
  // so it is treated as the shortest possible timeout of one tick.
  function automatic logic [CNT_W-1:0] eff_timeout(input logic [CNT_W-1:0] t);
    eff_timeout = (t == '0) ? ONE : t;
  endfunction

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             irq, irq_n;
  logic             rst_req, rst_req_n;
  logic             kerr, kerr_n;
  logic             tick_q;

  logic             tick_edge;
  logic [CNT_W-1:0] t1_last;
  logic [CNT_W-1:0] t2_last;
  logic             early_kick;
  logic             disable_req;

  always_comb begin
    tick_edge   = wdg_tick & ~tick_q;
    t1_last     = eff_timeout(cfg_timeout1) - ONE;
    t2_last     = eff_timeout(cfg_timeout2) - ONE;
    early_kick  = kick && (cfg_window != '0) && (cnt < cfg_window);
    disable_req = ALLOW_DISABLE && !cfg_en;
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    irq_n     = irq;
    rst_req_n = rst_req;
    kerr_n    = kerr;

    unique case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (cfg_en) state_n = ST_RUN;
      end

      ST_RUN: begin
        // A clear issued on the entry cycle to PREWARN is overridden below.
        if (irq_clr) irq_n = 1'b0;
        if (early_kick) begin
          state_n   = ST_EXPIRED;
          kerr_n    = 1'b1;
          rst_req_n = 1'b1;
        end else if (disable_req) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
          irq_n   = 1'b0;
        end else if (kick) begin
          cnt_n = '0;
        end else if (tick_edge) begin
          if (cnt == t1_last) begin
            state_n = ST_PREWARN;
            cnt_n   = '0;
            irq_n   = 1'b1;
          end else begin
            cnt_n = cnt + ONE;
          end
        end
      end

      ST_PREWARN: begin
        if (irq_clr) irq_n = 1'b0;
        // Expiry is checked before disable so a late disable cannot dodge it;
        // a kick in the same cycle still rescues the system.
        if (tick_edge && !kick && (cnt == t2_last)) begin
          state_n   = ST_EXPIRED;
          rst_req_n = 1'b1;
        end else if (disable_req) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
          irq_n   = 1'b0;
        end else if (kick) begin
          state_n = ST_RUN;
          cnt_n   = '0;
          irq_n   = 1'b0;
        end else if (tick_edge) begin
          cnt_n = cnt + ONE;
        end
      end

      ST_EXPIRED: begin
        rst_req_n = 1'b1;
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      irq     <= 1'b0;
      rst_req <= 1'b0;
      kerr    <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      irq     <= irq_n;
      rst_req <= rst_req_n;
      kerr    <= kerr_n;
      tick_q  <= wdg_tick;
    end
  end

  assign wdg_state   = state;
  assign wdg_cnt     = cnt;
  assign wdg_irq     = irq;
  assign wdg_rst_req = rst_req;
  assign kick_err    = kerr;

endmodule

// File: tb/tb_wdg_ctrl.sv
module tb_wdg_ctrl;

  logic        clk = 1'b0;
  logic        res;
  logic        wdg_tick;
  logic        cfg_en;
  logic [15:0] cfg_timeout1;
  logic [15:0] cfg_timeout2;
  logic [15:0] cfg_window;
  logic        kick;
  logic        irq_clr;

  logic        a_irq, a_rq, a_ke;
  logic [1:0]  a_state;
  logic [15:0] a_cnt;
  logic        b_irq, b_rq, b_ke;
  logic [1:0]  b_state;
  logic [15:0] b_cnt;

  always #5 clk = ~clk;

  wdg_ctrl #(.CNT_W(16), .ALLOW_DISABLE(1'b1)) dut_a (
    .clk(clk), .res(res), .wdg_tick(wdg_tick), .cfg_en(cfg_en),
    .cfg_timeout1(cfg_timeout1), .cfg_timeout2(cfg_timeout2), .cfg_window(cfg_window),
    .kick(kick), .irq_clr(irq_clr),
    .wdg_irq(a_irq), .wdg_rst_req(a_rq), .kick_err(a_ke),
    .wdg_state(a_state), .wdg_cnt(a_cnt)
  );

  wdg_ctrl #(.CNT_W(16), .ALLOW_DISABLE(1'b0)) dut_b (
    .clk(clk), .res(res), .wdg_tick(wdg_tick), .cfg_en(cfg_en),
    .cfg_timeout1(cfg_timeout1), .cfg_timeout2(cfg_timeout2), .cfg_window(cfg_window),
    .kick(kick), .irq_clr(irq_clr),
    .wdg_irq(b_irq), .wdg_rst_req(b_rq), .kick_err(b_ke),
    .wdg_state(b_state), .wdg_cnt(b_cnt)
  );

  typedef struct {
    logic        res, tick, en, kick, clr;
    logic [15:0] t1, t2, win;
    logic [1:0]  st;
    logic [15:0] cnt;
    logic        irq, rq, ke;
  } vec_t;

  vec_t        tbl[$];
  vec_t        sb[$];
  logic [15:0] c_t1, c_t2, c_win;
  int          n_tests = 0;
  int          n_fail  = 0;

  // ctl = {res, tick, en, kick, irq_clr}; fl = {irq, rst_req, kick_err}
  function automatic void add(input logic [4:0] ctl, input logic [1:0] st,
                              input logic [15:0] cnt, input logic [2:0] fl);
    vec_t v;
    {v.res, v.tick, v.en, v.kick, v.clr} = ctl;
    v.t1  = c_t1;
    v.t2  = c_t2;
    v.win = c_win;
    v.st  = st;
    v.cnt = cnt;
    {v.irq, v.rq, v.ke} = fl;
    tbl.push_back(v);
  endfunction

  task automatic apply(input int idx, input vec_t v);
    vec_t e;
    res          = v.res;
    wdg_tick     = v.tick;
    cfg_en       = v.en;
    kick         = v.kick;
    irq_clr      = v.clr;
    cfg_timeout1 = v.t1;
    cfg_timeout2 = v.t2;
    cfg_window   = v.win;
    sb.push_back(v);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    n_tests++;
    if ({a_state, a_cnt, a_irq, a_rq, a_ke} !== {e.st, e.cnt, e.irq, e.rq, e.ke}) begin
      n_fail++;
      $display("FAIL vec%0d: got st=%0d cnt=%0d irq=%b rst=%b kerr=%b, want st=%0d cnt=%0d irq=%b rst=%b kerr=%b",
               idx, a_state, a_cnt, a_irq, a_rq, a_ke, e.st, e.cnt, e.irq, e.rq, e.ke);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, n_tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

  initial begin
    res = 1'b1; wdg_tick = 1'b0; cfg_en = 1'b0; kick = 1'b0; irq_clr = 1'b0;
    cfg_timeout1 = '0; cfg_timeout2 = '0; cfg_window = '0;

    // Basic two-stage expiry, then EXPIRED is terminal.
    c_t1 = 16'd3; c_t2 = 16'd2; c_win = 16'd0;
    add(5'b10000, 2'd0, 16'd0, 3'b000);
    add(5'b00100, 2'd1, 16'd0, 3'b000);
    add(5'b01100, 2'd1, 16'd1, 3'b000);
    add(5'b01100, 2'd1, 16'd1, 3'b000);   // held high: one tick only
    add(5'b00100, 2'd1, 16'd1, 3'b000);
    add(5'b01100, 2'd1, 16'd2, 3'b000);
    add(5'b00100, 2'd1, 16'd2, 3'b000);
    add(5'b01100, 2'd2, 16'd0, 3'b100);   // 3rd edge -> PREWARN
    add(5'b00100, 2'd2, 16'd0, 3'b100);
    add(5'b01100, 2'd2, 16'd1, 3'b100);
    add(5'b00100, 2'd2, 16'd1, 3'b100);
    add(5'b01100, 2'd3, 16'd1, 3'b110);   // 2 more edges -> EXPIRED
    add(5'b00110, 2'd3, 16'd1, 3'b110);   // kick ignored
    add(5'b01011, 2'd3, 16'd1, 3'b110);   // kick, clr, en=0 ignored

    // Window: early kick is fatal; kick at cnt==window is legal.
    c_t1 = 16'd4; c_t2 = 16'd2; c_win = 16'd2;
    add(5'b10000, 2'd0, 16'd0, 3'b000);
    add(5'b00100, 2'd1, 16'd0, 3'b000);
    add(5'b01100, 2'd1, 16'd1, 3'b000);
    add(5'b00110, 2'd3, 16'd1, 3'b011);
    add(5'b00100, 2'd3, 16'd1, 3'b011);
    add(5'b10000, 2'd0, 16'd0, 3'b000);
    add(5'b00100, 2'd1, 16'd0, 3'b000);
    add(5'b01100, 2'd1, 16'd1, 3'b000);
    add(5'b00100, 2'd1, 16'd1, 3'b000);
    add(5'b01100, 2'd1, 16'd2, 3'b000);
    add(5'b00110, 2'd1, 16'd0, 3'b000);
    add(5'b01100, 2'd1, 16'd1, 3'b000);

    // PREWARN: set beats clear on entry, clear keeps state, kick returns to RUN.
    c_t1 = 16'd1; c_t2 = 16'd5; c_win = 16'd0;
    add(5'b10000, 2'd0, 16'd0, 3'b000);
    add(5'b00100, 2'd1, 16'd0, 3'b000);
    add(5'b01101, 2'd2, 16'd0, 3'b100);
    add(5'b00100, 2'd2, 16'd0, 3'b100);
    add(5'b01100, 2'd2, 16'd1, 3'b100);
    add(5'b00101, 2'd2, 16'd1, 3'b000);
    add(5'b01100, 2'd2, 16'd2, 3'b000);
    c_t1 = 16'd10;
    add(5'b00110, 2'd1, 16'd0, 3'b000);
    add(5'b01100, 2'd1, 16'd1, 3'b000);
    add(5'b00100, 2'd1, 16'd1, 3'b000);
    add(5'b01100, 2'd1, 16'd2, 3'b000);

    // Kick on the terminating tick wins; an early kick on a tick still expires.
    c_t1 = 16'd2; c_t2 = 16'd2; c_win = 16'd0;
    add(5'b10000, 2'd0, 16'd0, 3'b000);
    add(5'b00100, 2'd1, 16'd0, 3'b000);
    add(5'b01100, 2'd1, 16'd1, 3'b000);
    add(5'b00100, 2'd1, 16'd1, 3'b000);
    add(5'b01110, 2'd1, 16'd0, 3'b000);
    add(5'b00100, 2'd1, 16'd0, 3'b000);
    c_win = 16'd3;
    add(5'b01110, 2'd3, 16'd0, 3'b011);

    // Disable from PREWARN, then re-enable.
    c_t1 = 16'd1; c_t2 = 16'd5; c_win = 16'd0;
    add(5'b10000, 2'd0, 16'd0, 3'b000);
    add(5'b00100, 2'd1, 16'd0, 3'b000);
    add(5'b01100, 2'd2, 16'd0, 3'b100);
    add(5'b00000, 2'd0, 16'd0, 3'b000);
    add(5'b01000, 2'd0, 16'd0, 3'b000);
    add(5'b00100, 2'd1, 16'd0, 3'b000);

    // Zero timeouts act as 1; expiry beats a same-cycle disable.
    c_t1 = 16'd0; c_t2 = 16'd0; c_win = 16'd0;
    add(5'b10000, 2'd0, 16'd0, 3'b000);
    add(5'b00100, 2'd1, 16'd0, 3'b000);
    add(5'b01100, 2'd2, 16'd0, 3'b100);
    add(5'b00100, 2'd2, 16'd0, 3'b100);
    add(5'b01000, 2'd3, 16'd0, 3'b110);
    add(5'b00000, 2'd3, 16'd0, 3'b110);

    foreach (tbl[i]) apply(i, tbl[i]);

    // ALLOW_DISABLE=0 keeps counting after cfg_en drops; ALLOW_DISABLE=1 idles.
    res = 1'b1; wdg_tick = 1'b0; cfg_en = 1'b0; kick = 1'b0; irq_clr = 1'b0;
    cfg_timeout1 = 16'd3; cfg_timeout2 = 16'd1; cfg_window = 16'd0;
    @(negedge clk);
    res = 1'b0; cfg_en = 1'b1;
    @(negedge clk);
    cfg_en = 1'b0;
    @(negedge clk);
    chk("dis_a_idle", 32'(a_state), 32'd0);
    chk("nodis_b_run", 32'(b_state), 32'd1);
    for (int e = 1; e <= 4; e++) begin
      wdg_tick = 1'b1;
      @(negedge clk);
      wdg_tick = 1'b0;
      @(negedge clk);
      if (e == 2) chk("nodis_cnt2", 32'(b_cnt), 32'd2);
      if (e == 3) chk("nodis_prewarn", 32'({b_state, b_irq, b_rq}), 32'({2'd2, 1'b1, 1'b0}));
      if (e == 4) chk("nodis_expired", 32'({b_state, b_irq, b_rq}), 32'({2'd3, 1'b1, 1'b1}));
    end
    chk("dis_a_still_idle", 32'({a_state, a_cnt}), 32'({2'd0, 16'd0}));

    // Asynchronous reset in the middle of PREWARN.
    res = 1'b1;
    @(negedge clk);
    res = 1'b0; cfg_timeout1 = 16'd0; cfg_timeout2 = 16'd5; cfg_en = 1'b1;
    @(negedge clk);
    wdg_tick = 1'b1;
    @(negedge clk);
    chk("t1zero_prewarn", 32'({a_state, a_irq}), 32'({2'd2, 1'b1}));
    wdg_tick = 1'b0;
    #2 res = 1'b1;
    #1;
    chk("async_res_a", 32'({a_state, a_cnt, a_irq, a_rq, a_ke}), 32'd0);
    chk("async_res_b", 32'({b_state, b_cnt, b_irq, b_rq, b_ke}), 32'd0);
    @(negedge clk);
    res = 1'b0; cfg_en = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
